tone_sequencer: RTL

- Queued note player that sits directly upstream of the speaker driver and drives its 8-bit KEYS note-index input.
- The CPU output-port logic pushes {note, duration} pairs into a small FIFO.
- The block plays each note for an exact number of duration ticks, then holds an optional silent articulation gap, then plays the next entry.
- Note index 0 is silence; indices 1-36 select a pitch. Any other value is treated as a rest.

---
 rtl/tone_pkg.sv | 19 +
 rtl/tone_fifo.sv | 64 ++++++
 rtl/tone_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types for the queued tone player: FIFO entry layout, FSM states
// and the note-range clamp applied on the way to the speaker driver.
package tone_pkg;
  typedef logic [7:0] note_t;

  typedef struct packed {
    note_t      note;
    logic [7:0] dur;
  } tone_entry_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_t;

  localparam int unsigned MAX_NOTE = 36;

  // Out-of-range indices stay in the queue untouched but sound as a rest.
  function automatic note_t clamp_note(input note_t n);
    return (n > note_t'(MAX_NOTE)) ? '0 : n;
  endfunction
endpackage

// File: rtl/tone_fifo.sv
// Synchronous FIFO of tone entries with flush; FULL/EMPTY are registered.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module tone_fifo
  import tone_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  tone_entry_t wdata_i,
  output tone_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  tone_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && !empty_q && !flush_i;
  assign do_push = push_i && !flush_i && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                cnt_d = '0;
    else if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/tone_sequencer.sv
// Queued note player: pops {note, dur} entries and drives KEYS for dur ticks,
// followed by an optional silent gap, chaining entries without idle cycles.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_DIV   = 500_000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] NOTE_IN,
  input  logic [7:0] DUR_IN,
  input  logic       WR_EN,
  input  logic       STOP,
  input  logic       CLR_OVF,
  output logic [7:0] KEYS,
  output logic       BUSY,
  output logic       FULL,
  output logic       EMPTY,
  output logic       OVERFLOW,
  output logic       DONE
);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);
  localparam bit            HAS_GAP   = (GAP_TICKS > 0);

  if (TICK_DIV < 1 || CLK_HZ == 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("tone_sequencer: illegal parameter set");
  end

  seq_state_t    state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [7:0]    dur_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    keys_q, keys_d;
  logic          done_q, done_d, ovf_q, ovf_d;

  tone_entry_t head, wentry;
  logic        fifo_full, fifo_empty, pop;
  logic        tick_wrap, zero_ent, note_end, gap_end, advance;

  assign wentry = '{note: NOTE_IN, dur: DUR_IN};

  tone_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (WR_EN && !STOP),
    .pop_i   (pop),
    .flush_i (STOP),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // "advance" marks the point where the next entry may be taken: idle, the
  // one-cycle zero-duration slot, or the end of the note/gap.
  assign tick_wrap = (tick_q == TICK_LAST);
  assign zero_ent  = (state_q == PLAY) && (dur_q == '0);
  assign note_end  = (state_q == PLAY) && tick_wrap && (dur_q == 8'd1);
  assign gap_end   = (state_q == GAP) && tick_wrap && (gap_q == GW'(1));
  assign advance   = (state_q == IDLE) || zero_ent || gap_end || (note_end && !HAS_GAP);
  assign pop       = !STOP && advance && !fifo_empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (STOP) begin
      state_d = IDLE;
    end else if (advance) begin
      state_d = fifo_empty ? IDLE : PLAY;
    end else if (note_end) begin
      state_d = GAP;
    end
  end

  always_comb begin
    keys_d = keys_q;
    if (STOP)                               keys_d = '0;
    else if (pop)                           keys_d = (head.dur == '0) ? '0 : clamp_note(head.note);
    else if (note_end || state_d == IDLE)   keys_d = '0;
    done_d = !STOP && advance && fifo_empty && (state_q != IDLE);
    ovf_d  = ovf_q;
    if (CLR_OVF)                       ovf_d = 1'b0;
    if (WR_EN && fifo_full && !pop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q <= '0;
      dur_q  <= '0;
      gap_q  <= '0;
      keys_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      if (STOP) begin
        tick_q <= '0;
        dur_q  <= '0;
        gap_q  <= '0;
      end else if (pop) begin
        tick_q <= '0;
        dur_q  <= head.dur;
      end else if (state_q == PLAY && dur_q != '0) begin
        if (tick_wrap) begin
          tick_q <= '0;
          dur_q  <= dur_q - 8'd1;
          if (note_end && HAS_GAP) gap_q <= GAP_LOAD;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end else if (state_q == GAP) begin
        if (tick_wrap) begin
          tick_q <= '0;
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
    end
  end

  assign KEYS     = keys_q;
  assign BUSY     = (state_q != IDLE);
  assign FULL     = fifo_full;
  assign EMPTY    = fifo_empty;
  assign OVERFLOW = ovf_q;
  assign DONE     = done_q;
endmodule
